calc_arb_seq: RTL and testbench
===============================

Name: calc_arb_seq

Overview:
Sequential arithmetic scheduler that shares one 4-bit calculation datapath between two requesters. It covers add, subtract, multiply and divide operations.
- Arbitrates between the requesters and captures operands.
- Runs multiply as 4-step shift-add and divide as 4-step MSB-first restoring division.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between client logic and the arithmetic units, replacing per-client combinational multipliers and dividers.

Parameters:
W, 4, operand width (only 4 is supported; the iteration counter and result packing depend on it)
NREQ, 2, number of requesters (fixed at 2)

Ports:
clk  input  1  clock; single clock domain
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept (grant)
req_op  input  4  2 bits per requester: 00 add, 01 sub, 10 mul, 11 div
req_a  input  8  4-bit operand A per requester ([3:0] = requester 0)
req_b  input  8  4-bit operand B per requester
rsp_valid  output  1  result valid
rsp_ready  input  1  result accepted by the consumer
rsp_id  output  1  index of the requester served
rsp_data  output  8  result (packing given under Behaviour)
rsp_flag  output  1  add: carry out; sub: borrow; div: divide-by-zero; mul: 0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flag=0.
  - Iteration counter=0; last_grant=1, so requester 0 wins the first tie.
  - Reset overrides everything, including mid-operation. An in-flight operation is dropped with no response.
- States:
  - IDLE: req_ready is asserted combinationally for the granted requester only, and only when that requester's req_valid=1. On handshake, latch op/a/b/id and go to EXEC. No request means stay in IDLE.
  - EXEC, add/sub: completes in one cycle and goes to DONE.
  - EXEC, mul/div: cnt runs 3→0, one step per cycle, then goes to DONE. Request-accept to rsp_valid latency is 2 cycles (add/sub) or 5 cycles (mul/div).
  - DONE: rsp_valid=1. rsp_id, rsp_data and rsp_flag hold stable until rsp_ready=1. On that edge, return to IDLE with rsp_valid=0. There is no accept in the same cycle as the response handshake, so the minimum issue interval is 3 cycles.
- Arbitration:
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester != last_grant.
  - last_grant updates on each handshake.
  - A requester may drop req_valid before it is granted; nothing is captured in that case.
- Arithmetic:
  - add: rsp_data = {3'b0, a+b (5 bits)}; rsp_flag = bit 4 of the sum.
  - sub: rsp_data = {4'b0, (a-b) mod 16}; rsp_flag = (a<b).
  - mul: 8-bit accumulator. Step k adds b[k] ? (a<<k) : 0, with k=0..3 ascending. rsp_data = a*b.
  - div: remainder register starts at a. Step k (k=3..0): if rem ≥ (b<<k), subtract it and set q[k]. The comparison and subtraction are done in 8 bits, so b<<k never truncates. rsp_data = {rem[3:0], q[3:0]}.
  - div with b=0: skip iteration and go straight to DONE. q=4'hF, rem=a, rsp_flag=1.

Optional Feature:
CALC_RR_ARB_EN
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority. Requester 0 always wins a tie and last_grant is not implemented. All other behaviour is identical.

Decomposition:
- Package calc_pkg holds:
  - calc_op_e (ADD, SUB, MUL, DIV)
  - calc_state_e (IDLE, EXEC, DONE)
  - constants CALC_W=4 and CALC_ITER=4
  - the rsp_data packing widths
- Sub-module calc_iter_step, purely combinational: one mul or div step.
  - Inputs: op, k, accumulator/remainder, a, b.
  - Outputs: next accumulator/remainder and the quotient bit.
- The top level owns the FSM, counter, arbiter and registers.

Test Plan:
- Req0 div a=15 b=2, rsp_ready=1 → rsp_valid 5 cycles after accept; rsp_data=8'h17 (rem 1, q 7); rsp_flag=0; rsp_id=0.
- Req1 mul a=15 b=15 → rsp_data=8'hE1; id=1. Then sub a=3 b=5 → rsp_data=8'h0E, rsp_flag=1, 2-cycle latency.
- Both requesters valid continuously, each issuing add a=9 b=8 → grants alternate 0,1,0,1; rsp_data=8'h11, flag=1. With CALC_RR_ARB_EN undefined: grants are always 0.
- Div a=6 b=0 → DONE 2 cycles after accept; rsp_data=8'h6F; rsp_flag=1.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → outputs stable, req_ready=0 throughout. Release → one handshake, then IDLE.
- Reset: rst_n=0 during mul step 2 → next cycle all outputs 0. The re-issued request is served correctly, with requester 0 winning the first tie.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the calc_arb_seq arithmetic scheduler.
// Operand width is fixed at 4; the iteration counter and the result packing depend on it.
package calc_pkg;

    localparam int CALC_W     = 4;
    localparam int CALC_ITER  = 4;
    localparam int CALC_REM_W = CALC_W;
    localparam int CALC_Q_W   = CALC_W;
    localparam int CALC_RSP_W = CALC_REM_W + CALC_Q_W;
    localparam int CALC_ACC_W = 2 * CALC_W;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } calc_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } calc_state_e;

endpackage

// File: rtl/calc_iter_step.sv
// One combinational iteration of the shared datapath: a shift-add multiply step,
// or an MSB-first restoring divide step (compare and subtract in full accumulator width).
module calc_iter_step
    import calc_pkg::*;
(
    input  calc_op_e              op,
    input  logic [1:0]            k,
    input  logic [CALC_ACC_W-1:0] acc,
    input  logic [CALC_W-1:0]     a,
    input  logic [CALC_W-1:0]     b,
    output logic [CALC_ACC_W-1:0] acc_nxt,
    output logic                  qbit
);

    logic [CALC_ACC_W-1:0] a_sh;
    logic [CALC_ACC_W-1:0] b_sh;

    always_comb begin
        a_sh    = {{CALC_W{1'b0}}, a} << k;
        b_sh    = {{CALC_W{1'b0}}, b} << k;
        acc_nxt = acc;
        qbit    = 1'b0;
        if (op == MUL) begin
            if (b[k]) begin
                acc_nxt = acc + a_sh;
            end
        end else if (acc >= b_sh) begin
            acc_nxt = acc - b_sh;
            qbit    = 1'b1;
        end
    end

endmodule

// File: rtl/calc_arb_seq.sv
// Two-requester arithmetic scheduler sharing one 4-bit add/sub/mul/div datapath.
// CALC_RR_ARB_EN selects round-robin tie-break; undefined gives fixed priority to requester 0.
module calc_arb_seq
    import calc_pkg::*;
#(
    parameter int W    = CALC_W,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [2*W-1:0]    rsp_data,
    output logic              rsp_flag
);

    calc_state_e    state;
    calc_op_e       op_r;
    logic [1:0]     cnt;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           id_r;
    logic [2*W-1:0] acc_r;
    logic [W-2:0]   q_r;
`ifdef CALC_RR_ARB_EN
    logic           last_grant;
`endif

    logic           g;
    logic [1:0]     op_sel;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W:0]     sum;
    logic [W-1:0]   diff;
    logic [1:0]     k;
    logic [2*W-1:0] acc_nxt;
    logic           qbit;

    always_comb begin
`ifdef CALC_RR_ARB_EN
        g = (req_valid[0] && req_valid[1]) ? ~last_grant : ~req_valid[0];
`else
        g = ~req_valid[0];
`endif
        req_ready = '0;
        if (rst_n && state == IDLE && req_valid[g]) begin
            req_ready[g] = 1'b1;
        end
        op_sel = g ? req_op[3:2]     : req_op[1:0];
        a_sel  = g ? req_a[2*W-1:W]  : req_a[W-1:0];
        b_sel  = g ? req_b[2*W-1:W]  : req_b[W-1:0];
        sum    = {1'b0, a_r} + {1'b0, b_r};
        diff   = a_r - b_r;
        // cnt always counts down; multiply walks bits LSB-first, divide MSB-first
        k      = (op_r == MUL) ? 2'(CALC_ITER - 1) - cnt : cnt;
    end

    calc_iter_step u_step (
        .op      (op_r),
        .k       (k),
        .acc     (acc_r),
        .a       (a_r),
        .b       (b_r),
        .acc_nxt (acc_nxt),
        .qbit    (qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_r      <= ADD;
            a_r       <= '0;
            b_r       <= '0;
            id_r      <= 1'b0;
            acc_r     <= '0;
            q_r       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
`ifdef CALC_RR_ARB_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        op_r  <= calc_op_e'(op_sel);
                        a_r   <= a_sel;
                        b_r   <= b_sel;
                        id_r  <= g;
                        cnt   <= 2'(CALC_ITER - 1);
                        acc_r <= (calc_op_e'(op_sel) == DIV) ? {{W{1'b0}}, a_sel} : '0;
                        q_r   <= '0;
`ifdef CALC_RR_ARB_EN
                        last_grant <= g;
`endif
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_r)
                        ADD: begin
                            rsp_data  <= {{(W-1){1'b0}}, sum};
                            rsp_flag  <= sum[W];
                            rsp_valid <= 1'b1;
                            rsp_id    <= id_r;
                            state     <= DONE;
                        end
                        SUB: begin
                            rsp_data  <= {{W{1'b0}}, diff};
                            rsp_flag  <= (a_r < b_r);
                            rsp_valid <= 1'b1;
                            rsp_id    <= id_r;
                            state     <= DONE;
                        end
                        default: begin
                            if (op_r == DIV && b_r == '0) begin
                                rsp_data  <= {a_r, {W{1'b1}}};
                                rsp_flag  <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_id    <= id_r;
                                state     <= DONE;
                            end else begin
                                acc_r <= acc_nxt;
                                q_r   <= {q_r[W-3:0], qbit};
                                if (cnt == '0) begin
                                    rsp_data  <= (op_r == MUL) ? acc_nxt
                                                               : {acc_nxt[W-1:0], q_r, qbit};
                                    rsp_flag  <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_id    <= id_r;
                                    state     <= DONE;
                                end else begin
                                    cnt <= cnt - 2'd1;
                                end
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_arb_seq.sv
// Self-checking bench for calc_arb_seq: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model (honours CALC_RR_ARB_EN).
module tb_calc_arb_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [3:0] req_op = '0;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_flag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    calc_arb_seq #(.W(4), .NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_flag  (rsp_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // {flag, data} straight from the arithmetic definitions
    function automatic logic [8:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, s;
        sa = int'(a);
        sb = int'(b);
        case (op)
            2'd0: begin s = sa + sb; return {1'(s > 15), 8'(s)}; end
            2'd1: begin s = (sa - sb) & 15; return {1'(sa < sb), 8'(s)}; end
            2'd2: begin s = sa * sb; return {1'b0, 8'(s)}; end
            default: begin
                if (sb == 0) return {1'b1, a, 4'hF};
                return {1'b0, 4'(sa % sb), 4'(sa / sb)};
            end
        endcase
    endfunction

    function automatic int lat(input logic [1:0] op, input logic [3:0] b);
        if (op == 2'd0 || op == 2'd1 || (op == 2'd3 && b == 4'd0)) return 2;
        return 5;
    endfunction

    // transaction-level reference: at most one job outstanding
    logic       busy = 1'b0;
    logic       lg = 1'b1;
    logic       started = 1'b0;
    logic       zchk = 1'b0;
    logic [8:0] exp_r = '0;
    logic       exp_id = 1'b0;
    int         due = 0;

    always @(negedge clk) begin
        logic [1:0] er;
        logic       erv;
        int         g;
        erv = busy && (cyc >= due);
        if (started) begin
            chk("rsp_valid", rsp_valid, erv);
            if (erv) begin
                chk("rsp_id", rsp_id, exp_id);
                chk("rsp_data", rsp_data, exp_r[7:0]);
                chk("rsp_flag", rsp_flag, exp_r[8]);
            end
            if (zchk) begin
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_rsp_flag", rsp_flag, 0);
            end
        end
        er = 2'b00;
        if (rst_n && !busy) begin
`ifdef CALC_RR_ARB_EN
            if (req_valid == 2'b11) er = lg ? 2'b01 : 2'b10;
            else                    er = req_valid;
`else
            er = req_valid[0] ? 2'b01 : req_valid;
`endif
        end
        if (started) chk("req_ready", req_ready, er);
        zchk = 1'b0;
        if (!rst_n) begin
            busy    = 1'b0;
            lg      = 1'b1;
            started = 1'b1;
            zchk    = 1'b1;
        end else if (er != 2'b00) begin
            g      = er[1] ? 1 : 0;
            exp_r  = model(req_op[2*g +: 2], req_a[4*g +: 4], req_b[4*g +: 4]);
            exp_id = er[1];
            due    = cyc + lat(req_op[2*g +: 2], req_b[4*g +: 4]);
            busy   = 1'b1;
            lg     = er[1];
        end else if (erv && rsp_ready) begin
            busy = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, output int ac);
        req_op[2*r +: 2] = op;
        req_a[4*r +: 4]  = a;
        req_b[4*r +: 4]  = b;
        req_valid[r]     = 1'b1;
        ac = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ac = cyc;
                break;
            end
        end
        chk("accept_seen", ac >= 0, 1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output logic [7:0] d, output logic f, output logic id);
        rc = -1;
        d  = '0;
        f  = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rc = cyc;
                d  = rsp_data;
                f  = rsp_flag;
                id = rsp_id;
                break;
            end
        end
        chk("rsp_seen", rc >= 0, 1);
        tick();
    endtask

    initial begin
        int         ac, rc, n;
        logic [7:0] d;
        logic       f, id;
        logic       gr [4];

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        issue(0, 2'd3, 4'd15, 4'd2, ac);
        wait_rsp(rc, d, f, id);
        chk("div15_2_data", d, 8'h17);
        chk("div15_2_flag", f, 0);
        chk("div15_2_id", id, 0);
        chk("div15_2_lat", rc - ac, 5);

        issue(1, 2'd2, 4'd15, 4'd15, ac);
        wait_rsp(rc, d, f, id);
        chk("mul15_15_data", d, 8'hE1);
        chk("mul15_15_id", id, 1);
        chk("mul15_15_lat", rc - ac, 5);

        issue(1, 2'd1, 4'd3, 4'd5, ac);
        wait_rsp(rc, d, f, id);
        chk("sub3_5_data", d, 8'h0E);
        chk("sub3_5_flag", f, 1);
        chk("sub3_5_lat", rc - ac, 2);

        issue(1, 2'd3, 4'd6, 4'd0, ac);
        wait_rsp(rc, d, f, id);
        chk("div6_0_data", d, 8'h6F);
        chk("div6_0_flag", f, 1);
        chk("div6_0_lat", rc - ac, 2);

        // both requesters hold add 9+8; last grant so far was requester 1
        req_op    = 4'b0000;
        req_a     = {4'd9, 4'd9};
        req_b     = {4'd8, 4'd8};
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gr[n] = req_ready[1];
                n++;
            end
        end
        tick();
        req_valid = 2'b00;
        chk("grant_count", n, 4);
        for (int j = 0; j < 4; j++) begin
`ifdef CALC_RR_ARB_EN
            chk($sformatf("grant_%0d", j), gr[j], j % 2);
`else
            chk($sformatf("grant_%0d", j), gr[j], 0);
`endif
        end
        wait_rsp(rc, d, f, id);
        chk("add9_8_data", d, 8'h11);
        chk("add9_8_flag", f, 1);

        // backpressure: hold the response for 10 cycles with a competing request pending
        rsp_ready = 1'b0;
        issue(1, 2'd2, 4'd7, 4'd3, ac);
        wait_rsp(rc, d, f, id);
        chk("bp_data", d, 8'h15);
        req_op[1:0] = 2'd0;
        req_a[3:0]  = 4'd1;
        req_b[3:0]  = 4'd1;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 2'b00);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'h15);
            chk("bp_rsp_id", rsp_id, 1);
        end
        tick();
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_released", rsp_valid, 0);
        tick();

        // reset while the multiply is in its third step
        issue(0, 2'd2, 4'd13, 4'd11, ac);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", rsp_valid, 0);
        chk("rst_mid_data", rsp_data, 0);
        chk("rst_mid_ready", req_ready, 2'b00);
        tick();
        req_op    = {2'd1, 2'd2};
        req_a     = {4'd2, 4'd13};
        req_b     = {4'd9, 4'd11};
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_first_tie", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(rc, d, f, id);
        chk("reissue_data", d, 8'h8F);
        chk("reissue_id", id, 0);
        issue(1, 2'd1, 4'd2, 4'd9, ac);
        wait_rsp(rc, d, f, id);
        chk("sub2_9_data", d, 8'h09);
        chk("sub2_9_flag", f, 1);

        for (int i = 0; i < 600; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_op    = 4'($urandom);
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (i % 97 == 50) rst_n = 1'b0;
            else              rst_n = 1'b1;
            tick();
        end
        rst_n     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
